ifft8_seq: RTL and testbench

Sequential 8-point inverse FFT, the return path for the 8-point forward FFT core. Takes eight complex Q4.11 frequency-domain words and produces eight time-domain words scaled by 1/8. Uses one time-multiplexed radix-2 butterfly over an in-place 8-word register file, so each transform takes 12 butterfly cycles. Interfaces with a start/busy/done handshake.

---
 rtl/ifft8_seq.sv | 194 +++++++++++++++++++
 tb/tb_ifft8_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft8_seq.sv
// Purpose: sequential 8-point inverse FFT, Q4.11 complex words, output scaled by 1/8.
// Latency: 13 cycles start-to-done (12 butterflies + 1 writeback); back-to-back every 13.
// Backpressure: none; start is ignored while busy, except on the writeback cycle.
// Ports: ck/rst (async active-low) | start, x0..x7 in | busy, done pulse, f0..f7 out.
module ifft8_seq (
  input  logic        ck,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x0,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic [31:0] x3,
  input  logic [31:0] x4,
  input  logic [31:0] x5,
  input  logic [31:0] x6,
  input  logic [31:0] x7,
  output logic        busy,
  output logic        done,
  output logic [31:0] f0,
  output logic [31:0] f1,
  output logic [31:0] f2,
  output logic [31:0] f3,
  output logic [31:0] f4,
  output logic [31:0] f5,
  output logic [31:0] f6,
  output logic [31:0] f7
);

  // Conjugate twiddles {re, im}, Q4.11.
  localparam logic [31:0] W0 = 32'h0800_0000;
  localparam logic [31:0] W1 = 32'h05A8_05A8;
  localparam logic [31:0] W2 = 32'h0000_0800;
  localparam logic [31:0] W3 = 32'hFA58_05A8;

  // Steps 0..11 are butterflies; step 12 is the writeback cycle that
  // copies the finished register file to f and raises done.
  localparam logic [3:0] WB_ST = 4'd12;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  st_q, st_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] m_q [8];
  logic [31:0] m_d [8];
  logic [31:0] f_q [8];
  logic [31:0] f_d [8];

  // Pair / twiddle schedule decoded from the step counter.
  logic [2:0]  a_idx, b_idx;
  logic [1:0]  tw_sel;
  logic [31:0] tw, mv_a, mv_b;

  always_comb begin
    a_idx  = 3'd0;
    b_idx  = 3'd0;
    tw_sel = 2'd0;
    case (st_q[3:2])
      2'd0: begin  // stage 1: adjacent pairs
        a_idx = {st_q[1:0], 1'b0};
        b_idx = {st_q[1:0], 1'b1};
      end
      2'd1: begin  // stage 2: stride 2, W0/W2 alternating
        a_idx  = {st_q[1], 1'b0, st_q[0]};
        b_idx  = {st_q[1], 1'b1, st_q[0]};
        tw_sel = {st_q[0], 1'b0};
      end
      default: begin  // stage 3: stride 4, W0..W3
        a_idx  = {1'b0, st_q[1:0]};
        b_idx  = {1'b1, st_q[1:0]};
        tw_sel = st_q[1:0];
      end
    endcase
    case (tw_sel)
      2'd0:    tw = W0;
      2'd1:    tw = W1;
      2'd2:    tw = W2;
      default: tw = W3;
    endcase
  end

  assign mv_a = m_q[a_idx];
  assign mv_b = m_q[b_idx];

  // Four sign-magnitude partial products: rr, ii, ri, ir.
  // Truncating the magnitude before re-applying the sign rounds toward zero.
  logic [15:0] op_a [4];
  logic [15:0] op_b [4];
  logic [15:0] mag_a [4];
  logic [15:0] mag_b [4];
  logic [31:0] prod [4];
  logic [15:0] pp [4];

  always_comb begin
    op_a[0] = mv_b[31:16]; op_b[0] = tw[31:16];
    op_a[1] = mv_b[15:0];  op_b[1] = tw[15:0];
    op_a[2] = mv_b[31:16]; op_b[2] = tw[15:0];
    op_a[3] = mv_b[15:0];  op_b[3] = tw[31:16];
    for (int k = 0; k < 4; k++) begin
      // 0x8000 negates to 0x8000, which read unsigned is the correct magnitude.
      mag_a[k] = op_a[k][15] ? (16'd0 - op_a[k]) : op_a[k];
      mag_b[k] = op_b[k][15] ? (16'd0 - op_b[k]) : op_b[k];
      prod[k]  = {16'd0, mag_a[k]} * {16'd0, mag_b[k]};
      pp[k]    = (op_a[k][15] ^ op_b[k][15]) ? (16'd0 - prod[k][26:11]) : prod[k][26:11];
    end
  end

  logic [15:0] t_re, t_im;
  logic [16:0] sum_re, sum_im, dif_re, dif_im;
  logic [31:0] new_a, new_b;

  assign t_re   = pp[0] - pp[1];
  assign t_im   = pp[2] + pp[3];
  assign sum_re = {mv_a[31], mv_a[31:16]} + {t_re[15], t_re};
  assign sum_im = {mv_a[15], mv_a[15:0]}  + {t_im[15], t_im};
  assign dif_re = {mv_a[31], mv_a[31:16]} - {t_re[15], t_re};
  assign dif_im = {mv_a[15], mv_a[15:0]}  - {t_im[15], t_im};
  // Dropping bit 0 of the 17-bit result is the floor halving.
  assign new_a  = {sum_re[16:1], sum_im[16:1]};
  assign new_b  = {dif_re[16:1], dif_im[16:1]};

  logic unused_bits;
  assign unused_bits = ^{prod[0][31:27], prod[0][10:0], prod[1][31:27], prod[1][10:0],
                         prod[2][31:27], prod[2][10:0], prod[3][31:27], prod[3][10:0],
                         sum_re[0], sum_im[0], dif_re[0], dif_im[0]};

  logic last, accept;
  assign last   = (state_q == RUN) && (st_q == WB_ST);
  assign accept = start && ((state_q == IDLE) || last);

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    m_d     = m_q;
    f_d     = f_q;
    if (last) begin
      f_d    = m_q;
      done_d = 1'b1;
    end
    if (accept) begin
      // Bit-reversed load so results come out in natural order.
      m_d[0] = x0; m_d[1] = x4; m_d[2] = x2; m_d[3] = x6;
      m_d[4] = x1; m_d[5] = x5; m_d[6] = x3; m_d[7] = x7;
      st_d    = 4'd0;
      busy_d  = 1'b1;
      state_d = RUN;
    end else if (last) begin
      st_d    = 4'd0;
      busy_d  = 1'b0;
      state_d = IDLE;
    end else if (state_q == RUN) begin
      m_d[a_idx] = new_a;
      m_d[b_idx] = new_b;
      st_d       = st_q + 4'd1;
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      st_q    <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        m_q[i] <= 32'd0;
        f_q[i] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < 8; i++) begin
        m_q[i] <= m_d[i];
        f_q[i] <= f_d[i];
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign f0 = f_q[0];
  assign f1 = f_q[1];
  assign f2 = f_q[2];
  assign f3 = f_q[3];
  assign f4 = f_q[4];
  assign f5 = f_q[5];
  assign f6 = f_q[6];
  assign f7 = f_q[7];

endmodule

// File: tb/tb_ifft8_seq.sv
// Purpose: self-checking bench for ifft8_seq (scoreboard of expected f vectors).
// Latency: checks 13-cycle start-to-done and back-to-back acceptance.
// Backpressure: checks start is ignored while busy and reset aborts cleanly.
module tb_ifft8_seq;

  typedef logic [7:0][31:0] vec_t;

  logic ck = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [31:0] x0, x1, x2, x3, x4, x5, x6, x7;
  logic busy, done;
  logic [31:0] f0, f1, f2, f3, f4, f5, f6, f7;
  vec_t fv;

  int tests = 0;
  int fails = 0;
  vec_t exp_q[$];

  ifft8_seq dut (
    .ck(ck), .rst(rst), .start(start),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
    .busy(busy), .done(done),
    .f0(f0), .f1(f1), .f2(f2), .f3(f3), .f4(f4), .f5(f5), .f6(f6), .f7(f7)
  );

  always #5 ck = ~ck;
  assign fv = {f7, f6, f5, f4, f3, f2, f1, f0};

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_tw(input int i);
    case (i)
      0: return 32'h0800_0000;
      1: return 32'h05A8_05A8;
      2: return 32'h0000_0800;
      default: return 32'hFA58_05A8;
    endcase
  endfunction

  function automatic logic [15:0] ref_pp(input logic [15:0] a, input logic [15:0] b);
    int ia, ib, mag;
    ia = int'($signed(a));
    ib = int'($signed(b));
    mag = ((ia < 0 ? -ia : ia) * (ib < 0 ? -ib : ib)) / 2048;
    if ((ia < 0) != (ib < 0)) mag = -mag;
    return mag[15:0];
  endfunction

  function automatic logic [15:0] ref_half(input logic [15:0] a, input logic [15:0] b, input bit sub);
    int s;
    s = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
    s = s >>> 1;
    return s[15:0];
  endfunction

  function automatic vec_t ref_ifft(input vec_t x);
    logic [15:0] re [8];
    logic [15:0] im [8];
    logic [15:0] tr, ti, ar, ai;
    logic [31:0] w;
    vec_t r;
    for (int i = 0; i < 8; i++) begin
      int br;
      br = ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
      re[i] = x[br][31:16];
      im[i] = x[br][15:0];
    end
    for (int s = 0; s < 3; s++) begin
      int h, step;
      h = 1 << s;
      step = 4 >> s;
      for (int g = 0; g < 8; g += 2 * h) begin
        for (int k = 0; k < h; k++) begin
          int a, b;
          a = g + k;
          b = a + h;
          w = ref_tw(k * step);
          tr = ref_pp(re[b], w[31:16]) - ref_pp(im[b], w[15:0]);
          ti = ref_pp(re[b], w[15:0]) + ref_pp(im[b], w[31:16]);
          ar = re[a];
          ai = im[a];
          re[a] = ref_half(ar, tr, 1'b0);
          im[a] = ref_half(ai, ti, 1'b0);
          re[b] = ref_half(ar, tr, 1'b1);
          im[b] = ref_half(ai, ti, 1'b1);
        end
      end
    end
    for (int i = 0; i < 8; i++) r[i] = {re[i], im[i]};
    return r;
  endfunction

  // ---------------- constant stimulus / expectations ----------------
  function automatic vec_t single_x();
    vec_t v;
    v = '0;
    v[1] = 32'h0800_0000;
    return v;
  endfunction

  function automatic vec_t single_exp();
    vec_t v;
    v[0] = 32'h0100_0000; v[1] = 32'h00B5_00B5; v[2] = 32'h0000_0100; v[3] = 32'hFF4B_00B5;
    v[4] = 32'hFF00_0000; v[5] = 32'hFF4B_FF4B; v[6] = 32'h0000_FF00; v[7] = 32'h00B5_FF4B;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < 8; i++) v[i] = $urandom;
    return v;
  endfunction

  task automatic set_x(input vec_t v);
    x0 = v[0]; x1 = v[1]; x2 = v[2]; x3 = v[3];
    x4 = v[4]; x5 = v[5]; x6 = v[6]; x7 = v[7];
  endtask

  // Drive start for exactly one rising edge; returns 1 time unit after it.
  task automatic apply_start(input vec_t v);
    @(negedge ck);
    set_x(v);
    start = 1'b1;
    @(posedge ck);
    #1 start = 1'b0;
  endtask

  // Counts rising edges until done is seen; n = -1 on timeout.
  task automatic wait_done(input int maxc, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < maxc) begin
      @(posedge ck);
      n++;
      @(negedge ck);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) n = -1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge ck) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done=1 with no transform outstanding at %0t", $time);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        for (int k = 0; k < 8; k++) begin
          tests++;
          if (fv[k] !== e[k]) begin
            fails++;
            $display("FAIL result_f%0d: got %08h expected %08h at %0t", k, fv[k], e[k], $time);
          end
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge ck);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests++;
    if (fv !== '0) begin fails++; $display("FAIL reset_f: got %h expected 0", fv); end
    rst = 1'b1;
  endtask

  task automatic test_vectors();
    vec_t xs [4];
    vec_t es [4];
    int n;
    for (int c = 0; c < 4; c++) begin xs[c] = '0; es[c] = '0; end
    xs[0][0] = 32'h0800_0000;                                   // DC bin
    for (int k = 0; k < 8; k++) es[0][k] = 32'h0100_0000;
    for (int k = 0; k < 8; k++) xs[1][k] = 32'h0800_0000;       // flat spectrum
    es[1][0] = 32'h0800_0000;
    xs[2] = single_x();                                         // single bin
    es[2] = single_exp();
    xs[3][0] = 32'h7FFF_7FFF; xs[3][4] = 32'h7FFF_7FFF;         // full scale
    es[3][0] = 32'h1FFF_1FFF; es[3][2] = 32'h1FFF_1FFF;
    es[3][4] = 32'h1FFF_1FFF; es[3][6] = 32'h1FFF_1FFF;
    for (int c = 0; c < 4; c++) begin
      exp_q.push_back(es[c]);
      apply_start(xs[c]);
      wait_done(30, n);
      tests++;
      if (n !== 13) begin fails++; $display("FAIL vec%0d_latency: got %0d expected 13", c, n); end
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL vec%0d_busy_after: got %b expected 0", c, busy); end
      @(negedge ck);
      tests++;
      if (done !== 1'b0) begin fails++; $display("FAIL vec%0d_done_width: got %b expected 0", c, done); end
    end
  endtask

  task automatic test_hold_start();
    bit busy_ok;
    exp_q.push_back(single_exp());
    @(negedge ck);
    set_x(single_x());
    start = 1'b1;
    @(posedge ck);                          // E0
    busy_ok = 1'b1;
    repeat (12) begin
      @(negedge ck);
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
      set_x(rand_vec());
      @(posedge ck);
    end
    @(negedge ck);
    if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
    start = 1'b0;
    @(posedge ck);                          // E0+13
    @(negedge ck);
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL hold_done: got %b expected 1", done); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL hold_busy_fall: got %b expected 0", busy); end
    tests++;
    if (!busy_ok) begin fails++; $display("FAIL hold_busy_window: got 0 expected 1"); end
    @(negedge ck);
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL hold_done_width: got %b expected 0", done); end
  endtask

  task automatic test_back_to_back();
    vec_t xa, xb, ea, eb;
    bit held_ok;
    xa = rand_vec();
    xb = rand_vec();
    ea = ref_ifft(xa);
    eb = ref_ifft(xb);
    exp_q.push_back(ea);
    apply_start(xa);                        // E0
    repeat (12) @(posedge ck);              // E0+12
    @(negedge ck);
    set_x(xb);
    start = 1'b1;
    exp_q.push_back(eb);
    @(posedge ck);                          // E0+13: first done, second accepted
    #1 start = 1'b0;
    set_x(rand_vec());
    @(negedge ck);
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL b2b_first_done: got %b expected 1", done); end
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy_kept: got %b expected 1", busy); end
    @(posedge ck);                          // E0+14
    held_ok = 1'b1;
    repeat (12) begin
      @(negedge ck);
      if (fv !== ea || done !== 1'b0) held_ok = 1'b0;
      @(posedge ck);
    end                                     // ends at E0+26
    @(negedge ck);
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL b2b_second_done: got %b expected 1", done); end
    tests++;
    if (!held_ok) begin fails++; $display("FAIL b2b_hold_prev_f: got 0 expected 1"); end
  endtask

  task automatic test_reset_mid();
    int n;
    bit quiet;
    apply_start(rand_vec());                // E0, nothing expected
    repeat (5) @(posedge ck);               // now at E0+5: st=5
    #2 rst = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    tests++;
    if (fv !== '0) begin fails++; $display("FAIL rstmid_f: got %h expected 0", fv); end
    repeat (2) @(negedge ck);
    rst = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge ck);
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    tests++;
    if (!quiet) begin fails++; $display("FAIL rstmid_quiet: got 0 expected 1"); end
    exp_q.push_back(single_exp());
    apply_start(single_x());
    wait_done(30, n);
    tests++;
    if (n !== 13) begin fails++; $display("FAIL rstmid_restart_latency: got %0d expected 13", n); end
  endtask

  initial begin
    set_x('0);
    #1 rst = 1'b0;
    test_reset();
    test_vectors();
    test_hold_start();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge ck);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
